// File: rtl/int_dp_sequencer_if.sv
// Command channel between the host controller and int_dp_sequencer.
// The host drives valid and the command fields; the sequencer answers with ready.
interface int_dp_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [4:0] cmd_base;
    logic [5:0] cmd_count;
    logic [4:0] cmd_s;
    logic [4:0] cmd_t;
    logic [4:0] cmd_d;
    logic [4:0] cmd_fs;
    logic       cmd_hilo;

    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_count,
        output cmd_s, cmd_t, cmd_d, cmd_fs, cmd_hilo,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_count,
        input  cmd_s, cmd_t, cmd_d, cmd_fs, cmd_hilo,
        output cmd_ready
    );
endinterface

// File: rtl/int_dp_sequencer.sv
// Control sequencer for Integer_Datapath: runs LOAD / DUMP / EXEC / NOP commands
// and is the sole driver of the datapath register-file and ALU control inputs.
module int_dp_sequencer #(
    parameter logic [4:0] FS_PASS_T = 5'h01,
    parameter logic [2:0] Y_SEL_ALU = 3'd2
) (
    input  logic               clk,
    input  logic               reset,
    int_dp_sequencer_if.slave  cmd,
    output logic               mem_rd,
    output logic [4:0]         mem_addr,
    input  logic [31:0]        mem_data,
    output logic [4:0]         S_Addr,
    output logic [4:0]         T_Addr,
    output logic [4:0]         D_Addr,
    output logic [4:0]         FS,
    output logic               D_En,
    output logic               T_Sel,
    output logic               HILO_ld,
    output logic [2:0]         Y_Sel,
    output logic [31:0]        DT,
    input  logic [31:0]        D_OUT,
    output logic               dump_valid,
    output logic [4:0]         dump_addr,
    output logic [31:0]        dump_data,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD,
        ST_LD_TAIL,
        ST_DMP,
        ST_DMP_TAIL,
        ST_EX,
        ST_WB,
        ST_FIN
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_DUMP = 2'b10,
        OP_EXEC = 2'b11
    } op_t;

    state_t     state;
    logic [5:0] idx;
    logic [5:0] n_last;
    logic [4:0] d_r;
    logic       hilo_r;
    logic       dt_en;

    // Memory data arrives one cycle after mem_rd, exactly when its write is issued,
    // so DT is a gated pass-through instead of another register stage.
    assign DT = dt_en ? mem_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            idx           <= '0;
            n_last        <= '0;
            d_r           <= '0;
            hilo_r        <= 1'b0;
            dt_en         <= 1'b0;
            cmd.cmd_ready <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_rd        <= 1'b0;
            mem_addr      <= '0;
            S_Addr        <= '0;
            T_Addr        <= '0;
            D_Addr        <= '0;
            FS            <= '0;
            D_En          <= 1'b0;
            T_Sel         <= 1'b0;
            HILO_ld       <= 1'b0;
            Y_Sel         <= Y_SEL_ALU;
            dump_valid    <= 1'b0;
            dump_addr     <= '0;
            dump_data     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        cmd.cmd_ready <= 1'b0;
                        busy          <= 1'b1;
                        idx           <= '0;
                        n_last        <= (cmd.cmd_count == 6'd0) ? 6'd31 : cmd.cmd_count - 6'd1;
                        d_r           <= cmd.cmd_d;
                        hilo_r        <= cmd.cmd_hilo;
                        case (op_t'(cmd.cmd_op))
                            OP_LOAD: begin
                                state    <= ST_LD;
                                mem_rd   <= 1'b1;
                                mem_addr <= cmd.cmd_base;
                            end
                            OP_DUMP: begin
                                state  <= ST_DMP;
                                T_Addr <= cmd.cmd_base;
                                T_Sel  <= 1'b0;
                            end
                            OP_EXEC: begin
                                state   <= ST_EX;
                                S_Addr  <= cmd.cmd_s;
                                T_Addr  <= cmd.cmd_t;
                                FS      <= cmd.cmd_fs;
                                T_Sel   <= 1'b0;
                                HILO_ld <= cmd.cmd_hilo;
                            end
                            default: begin
                                state <= ST_FIN;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                end

                // Each LD cycle writes the word requested in the previous cycle.
                ST_LD: begin
                    D_En   <= 1'b1;
                    T_Sel  <= 1'b1;
                    FS     <= FS_PASS_T;
                    dt_en  <= 1'b1;
                    D_Addr <= mem_addr;
                    if (idx == n_last) begin
                        state  <= ST_LD_TAIL;
                        mem_rd <= 1'b0;
                    end else begin
                        idx      <= idx + 6'd1;
                        mem_addr <= mem_addr + 5'd1;
                    end
                end

                ST_LD_TAIL: begin
                    state <= ST_FIN;
                    done  <= 1'b1;
                    D_En  <= 1'b0;
                    T_Sel <= 1'b0;
                    dt_en <= 1'b0;
                end

                ST_DMP: begin
                    dump_valid <= 1'b1;
                    dump_data  <= D_OUT;
                    dump_addr  <= T_Addr;
                    if (idx == n_last) begin
                        state <= ST_DMP_TAIL;
                    end else begin
                        idx    <= idx + 6'd1;
                        T_Addr <= T_Addr + 5'd1;
                    end
                end

                ST_DMP_TAIL: begin
                    state      <= ST_FIN;
                    done       <= 1'b1;
                    dump_valid <= 1'b0;
                end

                ST_EX: begin
                    HILO_ld <= 1'b0;
                    if (hilo_r) begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                    end else begin
                        state  <= ST_WB;
                        D_En   <= 1'b1;
                        D_Addr <= d_r;
                        Y_Sel  <= Y_SEL_ALU;
                    end
                end

                ST_WB: begin
                    state <= ST_FIN;
                    done  <= 1'b1;
                    D_En  <= 1'b0;
                end

                ST_FIN: begin
                    state         <= ST_IDLE;
                    done          <= 1'b0;
                    busy          <= 1'b0;
                    cmd.cmd_ready <= 1'b1;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
